ast_hit_ctrl: RTL and testbench
===============================

AST_HIT_CTRL -- requirements
Module: ast_hit_ctrl

Interface
REQ-001 SHALL have parameter RESPAWN_FRAMES, default 60, frames between final destruction and the next new_asteroid.
REQ-002 SHALL have parameter COOLDOWN_FRAMES, default 2, frames after a hit during which overlaps are ignored.
REQ-003 SHALL have parameter SCORE_W, default 16, score counter width.
REQ-004 SHALL have port clk  input  1  the single system clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port vsync  input  1  frame-boundary strobe, already a 1-cycle pulse.
REQ-007 SHALL have port pixel_valid  input  1  current pixel is inside the active video area.
REQ-008 SHALL have port ast_pixel  input  1  the asteroid sprite is opaque at the current pixel.
REQ-009 SHALL have port torp_pixel  input  1  a torpedo is drawn at the current pixel.
REQ-010 SHALL have port game_start  input  1  1-cycle pulse that restarts the game.
REQ-011 SHALL have port new_asteroid  output  1  1-cycle pulse that spawns a large asteroid in the asteroid unit.
REQ-012 SHALL have port asteroid_hit  output  1  1-cycle pulse that splits the asteroid to its next size.
REQ-013 SHALL have port torpedo_kill  output  1  1-cycle pulse that retires the torpedo; coincident with asteroid_hit.
REQ-014 SHALL have port ast_alive  output  1  high while the asteroid may be drawn; used to gate the asteroid draw_mask.
REQ-015 SHALL have port stage  output  2  current size: 0=LARGE, 1=MED, 2=SMALL, 3=NONE.
REQ-016 SHALL have port score  output  SCORE_W  accumulated score.

Function
REQ-017 SHALL implement FSM states IDLE, ALIVE and RESPAWN; IDLE SHALL be the reset state.
REQ-018 SHALL, on game_start in any state, pulse new_asteroid in the next cycle, clear score, set stage=0, clear the hit latch and cooldown, and enter ALIVE.
REQ-019 SHALL set the hit latch on any cycle where state=ALIVE, cooldown=0, and pixel_valid, ast_pixel and torp_pixel are all 1.
REQ-020 SHALL, on vsync with the latch set, pulse asteroid_hit and torpedo_kill together in the next cycle and clear the latch.
REQ-021 SHALL, on each such hit, add the points for the current stage before it increments: 20 for LARGE, 50 for MED, 100 for SMALL.
REQ-022 SHALL, on each such hit, increment stage and load cooldown with COOLDOWN_FRAMES.
REQ-023 SHALL, on a hit at stage=SMALL, set stage=NONE, deassert ast_alive and enter RESPAWN with the frame counter loaded to RESPAWN_FRAMES.
REQ-024 SHALL decrement cooldown by 1 on each vsync while it is nonzero, and SHALL NOT let it go below 0.
REQ-025 SHALL decrement the frame counter on each vsync while in RESPAWN.
REQ-026 SHALL, on the vsync that brings the frame counter to 0, pulse new_asteroid in the next cycle, set stage=0 and enter ALIVE.
REQ-027 SHALL drive ast_alive as (state==ALIVE), registered.
REQ-028 SHALL give game_start priority when it coincides with vsync: a pending latch is discarded, no asteroid_hit is issued, and no points are added.
REQ-029 SHALL treat an overlap on the same cycle as vsync as belonging to the next frame, i.e. the latch sets after that vsync is evaluated.
REQ-030 SHALL saturate score at 2^SCORE_W-1 and never wrap.
REQ-031 SHALL never assert asteroid_hit or new_asteroid in the same cycle.
REQ-032 SHALL treat RESPAWN_FRAMES=0 as 1.

Reset
REQ-033 SHALL, in the cycle after rst, hold state=IDLE, stage=3, score=0, latch=0, cooldown=0, frame counter=0, and all pulse outputs and ast_alive at 0.
REQ-034 SHALL abort any pending hit or respawn when rst is asserted mid-operation, and SHALL emit no pulse in the cycle after rst deasserts.

Configuration
REQ-035 SHALL, with macro AST_SCORE_EN defined, implement the score adder and register as specified above.
REQ-036 SHALL, without AST_SCORE_EN, tie score to 0 and synthesize no score logic; all other behaviour SHALL be unchanged.

Verification (RESPAWN_FRAMES=3, COOLDOWN_FRAMES=2)
REQ-037 Scenario: rst then game_start -> new_asteroid=1 for exactly one cycle; ast_alive=1, stage=0, score=0.
REQ-038 Scenario: overlap pixel during frame, then vsync -> asteroid_hit=1 and torpedo_kill=1 the cycle after vsync; stage=1, score=20.
REQ-039 Scenario: overlap during each of the 2 frames following a hit -> no asteroid_hit; an overlap in the 3rd frame -> hit, stage=2, score=70.
REQ-040 Scenario: hit at SMALL -> score=170, stage=3, ast_alive=0; new_asteroid pulses 1 cycle after the 3rd subsequent vsync; stage=0.
REQ-041 Scenario: game_start coinciding with vsync while the latch is set -> no asteroid_hit; new_asteroid=1; score=0.
REQ-042 Scenario: with SCORE_W=6 and repeated hits, score saturates at 63; without AST_SCORE_EN, score stays 0 throughout.

Source files
------------

// File: rtl/ast_hit_ctrl.sv
// Asteroid/torpedo hit controller: latches overlaps per frame, splits the asteroid, scores, respawns.
// Optional score logic is built only when AST_SCORE_EN is defined; otherwise score is tied to 0.
module ast_hit_ctrl #(
  parameter int unsigned RESPAWN_FRAMES  = 60,
  parameter int unsigned COOLDOWN_FRAMES = 2,
  parameter int unsigned SCORE_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vsync,
  input  logic               pixel_valid,
  input  logic               ast_pixel,
  input  logic               torp_pixel,
  input  logic               game_start,
  output logic               new_asteroid,
  output logic               asteroid_hit,
  output logic               torpedo_kill,
  output logic               ast_alive,
  output logic [1:0]         stage,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ALIVE   = 2'd1,
    RESPAWN = 2'd2
  } state_t;

  localparam int unsigned RESP_EFF = (RESPAWN_FRAMES == 0) ? 1 : RESPAWN_FRAMES;
  localparam int FC_W = $clog2(RESP_EFF + 1);
  localparam int CD_W = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(RESP_EFF);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);

  state_t          state;
  logic            hit_latch;
  logic [CD_W-1:0] cooldown;
  logic [FC_W-1:0] frame_cnt;

  logic            overlap;
  logic            hit_now;
  logic            last_hit;
  logic [CD_W-1:0] cd_next;
  logic            latch_set;

  assign fsm_state = state;

  // An overlap seen on a vsync cycle is judged against the post-vsync cooldown,
  // so it counts toward the frame that vsync opens.
  always_comb begin
    overlap  = pixel_valid & ast_pixel & torp_pixel;
    hit_now  = (state == ALIVE) && vsync && hit_latch && !game_start;
    last_hit = hit_now && (stage == 2'd2);
    cd_next  = cooldown;
    if (vsync) begin
      if (hit_now)
        cd_next = CD_LOAD;
      else if (cooldown != '0)
        cd_next = cooldown - CD_W'(1);
    end
    latch_set = overlap && (state == ALIVE) && !last_hit && (cd_next == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      stage        <= 2'd3;
      hit_latch    <= 1'b0;
      cooldown     <= '0;
      frame_cnt    <= '0;
      new_asteroid <= 1'b0;
      asteroid_hit <= 1'b0;
      torpedo_kill <= 1'b0;
      ast_alive    <= 1'b0;
    end else begin
      new_asteroid <= 1'b0;
      asteroid_hit <= 1'b0;
      torpedo_kill <= 1'b0;
      if (game_start) begin
        // Restart wins over anything else this cycle, including a pending hit.
        state        <= ALIVE;
        stage        <= 2'd0;
        hit_latch    <= 1'b0;
        cooldown     <= '0;
        frame_cnt    <= '0;
        new_asteroid <= 1'b1;
        ast_alive    <= 1'b1;
      end else begin
        cooldown <= cd_next;
        case (state)
          IDLE: begin
            hit_latch <= 1'b0;
          end
          ALIVE: begin
            hit_latch <= (vsync ? 1'b0 : hit_latch) | latch_set;
            if (hit_now) begin
              asteroid_hit <= 1'b1;
              torpedo_kill <= 1'b1;
              stage        <= stage + 2'd1;
              if (last_hit) begin
                state     <= RESPAWN;
                ast_alive <= 1'b0;
                frame_cnt <= FC_LOAD;
              end
            end
          end
          RESPAWN: begin
            hit_latch <= 1'b0;
            if (vsync) begin
              frame_cnt <= frame_cnt - FC_W'(1);
              if (frame_cnt == FC_W'(1)) begin
                state        <= ALIVE;
                stage        <= 2'd0;
                new_asteroid <= 1'b1;
                ast_alive    <= 1'b1;
              end
            end
          end
          default: begin
            state     <= IDLE;
            hit_latch <= 1'b0;
            ast_alive <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef AST_SCORE_EN
  localparam int SW1 = ((SCORE_W > 7) ? SCORE_W : 7) + 1;
  localparam logic [SW1-1:0] SCORE_MAX = SW1'({SCORE_W{1'b1}});

  logic [SCORE_W-1:0] score_q;
  logic [6:0]         points;
  logic [SW1-1:0]     sum_w;

  always_comb begin
    case (stage)
      2'd0:    points = 7'd20;
      2'd1:    points = 7'd50;
      2'd2:    points = 7'd100;
      default: points = 7'd0;
    endcase
    sum_w = SW1'(score_q) + SW1'(points);
  end

  always_ff @(posedge clk) begin
    if (rst || game_start)
      score_q <= '0;
    else if (hit_now)
      score_q <= (sum_w > SCORE_MAX) ? {SCORE_W{1'b1}} : sum_w[SCORE_W-1:0];
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

endmodule

// File: tb/tb_ast_hit_ctrl.sv
// Bench for ast_hit_ctrl: directed frames, expected pulses queued by the driver, checked by a monitor.
// A second instance with a 6-bit score shares the stimulus to exercise saturation.
module tb_ast_hit_ctrl;

  localparam int EXP_W = 58;
  localparam logic K_NEW = 1'b0;
  localparam logic K_HIT = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vsync = 1'b0, pixel_valid = 1'b0, ast_pixel = 1'b0, torp_pixel = 1'b0, game_start = 1'b0;

  logic        new_a, hit_a, torp_a, alive_a;
  logic [1:0]  stage_a, st_a;
  logic [15:0] score_a;
  logic        new_b, hit_b, torp_b, alive_b;
  logic [1:0]  stage_b, st_b;
  logic [5:0]  score_b;

  int unsigned cyc = 0;
  int n_checks = 0;
  int n_fail   = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] e;

  ast_hit_ctrl #(.RESPAWN_FRAMES(3), .COOLDOWN_FRAMES(2), .SCORE_W(16)) dut_a (
    .clk(clk), .rst(rst), .vsync(vsync), .pixel_valid(pixel_valid), .ast_pixel(ast_pixel),
    .torp_pixel(torp_pixel), .game_start(game_start), .new_asteroid(new_a), .asteroid_hit(hit_a),
    .torpedo_kill(torp_a), .ast_alive(alive_a), .stage(stage_a), .score(score_a), .fsm_state(st_a)
  );

  ast_hit_ctrl #(.RESPAWN_FRAMES(3), .COOLDOWN_FRAMES(2), .SCORE_W(6)) dut_b (
    .clk(clk), .rst(rst), .vsync(vsync), .pixel_valid(pixel_valid), .ast_pixel(ast_pixel),
    .torp_pixel(torp_pixel), .game_start(game_start), .new_asteroid(new_b), .asteroid_hit(hit_b),
    .torpedo_kill(torp_b), .ast_alive(alive_b), .stage(stage_b), .score(score_b), .fsm_state(st_b)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] exp16(input int s);
`ifdef AST_SCORE_EN
    return 16'(s);
`else
    return 16'(0 * s);
`endif
  endfunction

  function automatic logic [5:0] exp6(input int s);
`ifdef AST_SCORE_EN
    return (s > 63) ? 6'd63 : 6'(s);
`else
    return 6'(0 * s);
`endif
  endfunction

  // Driver tasks
  task automatic step(input logic vs, input logic pv, input logic ap, input logic tp, input logic gs);
    vsync = vs; pixel_valid = pv; ast_pixel = ap; torp_pixel = tp; game_start = gs;
    @(posedge clk);
    #1;
    vsync = 1'b0; pixel_valid = 1'b0; ast_pixel = 1'b0; torp_pixel = 1'b0; game_start = 1'b0;
  endtask

  task automatic push(input logic kind, input logic [1:0] stg, input int s, input logic alive);
    exp_q.push_back({kind, 32'(cyc + 1), stg, exp16(s), exp6(s), alive});
  endtask

  task automatic hit_frame(input logic [1:0] stg, input int s, input logic alive);
    step(0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    push(K_HIT, stg, s, alive);
    step(1, 0, 0, 0, 0);
  endtask

  task automatic quiet_vsyncs(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_state"}, 32'(st_a), 32'd0);
    check({tag, "_stage"}, 32'(stage_a), 32'd3);
    check({tag, "_score"}, 32'(score_a), 32'd0);
    check({tag, "_score6"}, 32'(score_b), 32'd0);
    check({tag, "_alive"}, 32'(alive_a), 32'd0);
    check({tag, "_pulses"}, {29'd0, new_a, hit_a, torp_a}, 32'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (new_a || hit_a || torp_a) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got new=%0d hit=%0d kill=%0d expected none (cycle %0d)",
                 new_a, hit_a, torp_a, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle", 32'(cyc), e[56:25]);
        check("new_asteroid", 32'(new_a), 32'(!e[57]));
        check("asteroid_hit", 32'(hit_a), 32'(e[57]));
        check("torpedo_kill", 32'(torp_a), 32'(e[57]));
        check("stage", 32'(stage_a), 32'(e[24:23]));
        check("score", 32'(score_a), 32'(e[22:7]));
        check("score6", 32'(score_b), 32'(e[6:1]));
        check("ast_alive", 32'(alive_a), 32'(e[0]));
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");

    // Idle ignores vsync and overlaps
    step(1, 1, 1, 1, 0);
    step(0, 1, 1, 1, 0);
    step(1, 0, 0, 0, 0);

    push(K_NEW, 2'd0, 0, 1'b1);
    step(0, 0, 0, 0, 1);

    hit_frame(2'd1, 20, 1'b1);
    // Two cooldown frames swallow overlaps, third frame scores
    repeat (2) begin
      step(0, 1, 1, 1, 0);
      step(1, 0, 0, 0, 0);
    end
    hit_frame(2'd2, 70, 1'b1);
    quiet_vsyncs(2);

    // Partial overlaps never latch
    step(0, 0, 1, 1, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0);

    // Overlap on the vsync cycle belongs to the next frame
    step(1, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    push(K_HIT, 2'd3, 170, 1'b0);
    step(1, 0, 0, 0, 0);
    check("respawn_state", 32'(st_a), 32'd2);

    // Respawn ignores overlaps and counts 3 vsyncs
    step(0, 1, 1, 1, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0);
    step(1, 0, 0, 0, 0);
    check("respawn_alive", 32'(alive_a), 32'd0);
    step(0, 0, 0, 0, 0);
    push(K_NEW, 2'd0, 170, 1'b1);
    step(1, 0, 0, 0, 0);

    // Second round drives the 6-bit score into saturation
    hit_frame(2'd1, 190, 1'b1);
    quiet_vsyncs(2);
    hit_frame(2'd2, 240, 1'b1);
    quiet_vsyncs(2);
    hit_frame(2'd3, 340, 1'b0);
    quiet_vsyncs(2);
    step(0, 0, 0, 0, 0);
    push(K_NEW, 2'd0, 340, 1'b1);
    step(1, 0, 0, 0, 0);

    // game_start on the vsync that would have scored a pending hit
    step(0, 1, 1, 1, 0);
    push(K_NEW, 2'd0, 0, 1'b1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    hit_frame(2'd1, 20, 1'b1);

    // Reset mid-operation with a latched hit and coincident vsync
    quiet_vsyncs(2);
    step(0, 1, 1, 1, 0);
    rst = 1'b1;
    step(1, 0, 0, 0, 0);
    rst = 1'b0;
    check_reset_state("mid_reset");
    step(1, 1, 1, 1, 0);
    repeat (3) step(0, 0, 0, 0, 0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
